// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state encoding and width helpers for the neuron layer sequencer
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_CAPT  = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } seq_state_t;

  // Neuron output width: product width plus accumulation growth, bias headroom and sign.
  function automatic int nn_ow(input int m, input int n, input int k);
    return n + k + $clog2(m) + 2;
  endfunction

  function automatic int nn_iw(input int p);
    return $clog2(p);
  endfunction

endpackage

// File: rtl/neuron_param_fetch.sv
// rtl/neuron_param_fetch.sv - parameter memory read strobe and weight/bias capture registers
module neuron_param_fetch #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int B  = 10,
  parameter int IW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fetch,
  input  logic             i_wait,
  input  logic [IW-1:0]    i_idx,
  output logic             o_prm_rd,
  output logic [IW-1:0]    o_prm_addr,
  input  logic [M*N-1:0]   i_prm_weigth,
  input  logic [B:0]       i_prm_bias,
  output logic [M*N-1:0]   o_weigth,
  output logic [B:0]       o_bias
);

  logic [M*N-1:0] r_weigth;
  logic [B:0]     r_bias;

  // Memory returns data one cycle after the strobe, i.e. during WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_weigth <= '0;
      r_bias   <= '0;
    end else if (i_wait) begin
      r_weigth <= i_prm_weigth;
      r_bias   <= i_prm_bias;
    end
  end

  assign o_prm_rd   = i_fetch;
  assign o_prm_addr = i_fetch ? i_idx : '0;
  assign o_weigth   = r_weigth;
  assign o_bias     = r_bias;

endmodule

// File: rtl/neuron_layer_seq.sv
// rtl/neuron_layer_seq.sv - sequences one shared neuron over a P-neuron layer with a valid/ready result port
module neuron_layer_seq
  import nn_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 4,
  parameter int B = 10,
  parameter int P = 8,
  localparam int OW = nn_ow(M, N, K),
  localparam int IW = nn_iw(P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [M*K-1:0]   act_in,
  output logic             busy,
  output logic             done,
  output logic             prm_rd,
  output logic [IW-1:0]    prm_addr,
  input  logic [M*N-1:0]   prm_weigth,
  input  logic [B:0]       prm_bias,
  output logic             load_params,
  output logic [M*K-1:0]   activation,
  output logic [M*N-1:0]   weigth,
  output logic [B:0]       bias,
  input  logic [OW-1:0]    neu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OW-1:0]    res_data,
  output logic [IW-1:0]    res_idx
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_res_idx;
  logic [M*K-1:0]   r_act;
  logic [OW-1:0]    r_res_data;
  logic             w_last;

  assign w_last = (r_idx == IW'(P - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_act      <= '0;
      r_res_data <= '0;
      r_res_idx  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_act <= act_in;
          r_idx <= '0;
        end
        S_CAPT: begin
          r_res_data <= neu_out;
          r_res_idx  <= r_idx;
        end
        S_OUT: if (res_ready && !w_last) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_LOAD;
      S_LOAD:  w_next = S_CAPT;
      S_CAPT:  w_next = S_OUT;
      S_OUT:   if (res_ready) w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  neuron_param_fetch #(.M(M), .N(N), .B(B), .IW(IW)) u_fetch (
    .clk          (clk),
    .rst          (rst),
    .i_fetch      (r_state == S_FETCH),
    .i_wait       (r_state == S_WAIT),
    .i_idx        (r_idx),
    .o_prm_rd     (prm_rd),
    .o_prm_addr   (prm_addr),
    .i_prm_weigth (prm_weigth),
    .i_prm_bias   (prm_bias),
    .o_weigth     (weigth),
    .o_bias       (bias)
  );

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign load_params = (r_state == S_LOAD);
  assign res_valid   = (r_state == S_OUT);
  assign activation  = r_act;
  assign res_data    = r_res_data;
  assign res_idx     = r_res_idx;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb/tb_neuron_layer_seq.sv - directed and random checks of neuron_layer_seq with a neuron model and 1-cycle parameter ROM
module tb_neuron_layer_seq;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int B  = 10;
  localparam int P  = 8;
  localparam int OW = N + K + $clog2(M) + 2;
  localparam int IW = $clog2(P);
  localparam int AW = M * K;
  localparam int WW = M * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] act_in = '0;
  logic          busy, done, prm_rd, load_params, res_valid;
  logic [IW-1:0] prm_addr, res_idx;
  logic [WW-1:0] prm_weigth = '0;
  logic [B:0]    prm_bias = '0;
  logic [AW-1:0] activation;
  logic [WW-1:0] weigth;
  logic [B:0]    bias;
  logic [OW-1:0] neu_out, res_data;
  logic          res_ready = 1'b0;

  logic [WW-1:0] rom_w [P];
  logic [B:0]    rom_b [P];

  int errors = 0;
  int checks = 0;

  int q_idx[$];
  int q_data[$];
  int q_cyc[$];
  int done_cnt, done_cyc, prm_cnt, load_cnt, first_load;
  int hold_changed, prm_during_hold, hs_cyc, resume_cyc, resume_addr, timed_out;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prm_rd) begin
      prm_weigth <= rom_w[prm_addr];
      prm_bias   <= rom_b[prm_addr];
    end
  end

  function automatic logic [OW-1:0] golden(input logic [AW-1:0] a, input logic [WW-1:0] w,
                                           input logic [B:0] b);
    int s;
    int av;
    int wv;
    s = $signed(b);
    for (int i = 0; i < M; i++) begin
      av = $signed(a[i*K +: K]);
      wv = $signed(w[i*N +: N]);
      s += av * wv;
    end
    if (s < 0) s = 0;
    return OW'(s);
  endfunction

  assign neu_out = golden(activation, weigth, bias);

  neuron_layer_seq #(.M(M), .N(N), .K(K), .B(B), .P(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .act_in      (act_in),
    .busy        (busy),
    .done        (done),
    .prm_rd      (prm_rd),
    .prm_addr    (prm_addr),
    .prm_weigth  (prm_weigth),
    .prm_bias    (prm_bias),
    .load_params (load_params),
    .activation  (activation),
    .weigth      (weigth),
    .bias        (bias),
    .neu_out     (neu_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_idx     (res_idx)
  );

  // Starts a layer and records handshakes per cycle; cycle 1 is the one after the start edge.
  task automatic run_layer(input int hold_idx, input int hold_len, input int sp_a, input int sp_b,
                           input int sp_c, input int rst_cyc, input bit rnd);
    int held;
    bit hold_done;
    logic [OW-1:0] hd;
    logic [IW-1:0] hi;
    q_idx.delete(); q_data.delete(); q_cyc.delete();
    done_cnt = 0; done_cyc = 0; prm_cnt = 0; load_cnt = 0; first_load = 0;
    hold_changed = 0; prm_during_hold = 0; hs_cyc = 0; resume_cyc = 0; resume_addr = -1;
    timed_out = 0; held = 0; hold_done = 0; hd = '0; hi = '0;
    @(negedge clk); start = 1'b1; res_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      start = (c == sp_a) || (c == sp_b) || (c == sp_c);
      if (c == rst_cyc) rst = 1'b1;
      if (rnd) res_ready = 1'($urandom_range(0, 1));
      else if (!hold_done && res_valid && (int'(res_idx) == hold_idx)) begin
        if (held == 0) begin hd = res_data; hi = res_idx; end
        if (held < hold_len) begin
          res_ready = 1'b0;
          held++;
          if (res_data !== hd || res_idx !== hi) hold_changed++;
          if (prm_rd) prm_during_hold++;
        end else begin
          res_ready = 1'b1; hold_done = 1'b1; hs_cyc = c;
        end
      end else res_ready = 1'b1;
      if (res_valid && res_ready) begin
        q_idx.push_back(int'(res_idx)); q_data.push_back(int'(res_data)); q_cyc.push_back(c);
      end
      if (prm_rd) begin
        prm_cnt++;
        if (hold_done && resume_cyc == 0) begin resume_cyc = c; resume_addr = int'(prm_addr); end
      end
      if (load_params) begin
        load_cnt++;
        if (first_load == 0) first_load = c;
      end
      if (done) begin done_cnt++; done_cyc = c; return; end
      if (c == rst_cyc) return;
      @(negedge clk);
    end
    timed_out = 1;
  endtask

  task automatic fill_uniform(input logic [AW-1:0] a, input logic [WW-1:0] w, input int b0, input int bstep);
    act_in = a;
    for (int i = 0; i < P; i++) begin
      rom_w[i] = w;
      rom_b[i] = (B+1)'(b0 + bstep * i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, prm_rd, prm_addr, load_params, activation, weigth, bias, res_valid, res_data, res_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b prm_rd=%b addr=%0d load=%b act=%h w=%h b=%h valid=%b data=%h idx=%0d, want all 0",
               busy, done, prm_rd, prm_addr, load_params, activation, weigth, bias, res_valid, res_data, res_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    fill_uniform({4{4'h1}}, {4{4'h2}}, 3, 0);
    run_layer(-1, 0, 0, 0, 0, 0, 1'b0);
    checks++;
    if (q_idx.size() != 8 || timed_out != 0) begin
      errors++; $display("FAIL basic_count: got %0d results timeout=%0d, want 8 results", q_idx.size(), timed_out);
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      checks++;
      if (q_idx[i] != i || q_data[i] != 11 || q_cyc[i] != 5 * (i + 1)) begin
        errors++;
        $display("FAIL basic_result%0d: got idx=%0d data=%0d cycle=%0d, want idx=%0d data=11 cycle=%0d",
                 i, q_idx[i], q_data[i], q_cyc[i], i, 5 * (i + 1));
      end
    end
    checks++;
    if (first_load != 3 || load_cnt != 8) begin
      errors++; $display("FAIL basic_load: first=%0d count=%0d, want first=3 count=8", first_load, load_cnt);
    end
    checks++;
    if (prm_cnt != 8) begin errors++; $display("FAIL basic_prm_rd: count=%0d want 8", prm_cnt); end
    checks++;
    if (done_cnt != 1 || done_cyc != 41) begin
      errors++; $display("FAIL basic_done: count=%0d cycle=%0d, want count=1 cycle=41", done_cnt, done_cyc);
    end
  endtask

  task automatic test_relu();
    fill_uniform({4{4'h1}}, {4{4'h1}}, -20, 0);
    run_layer(-1, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < P; i++) begin
      checks++;
      if (q_data.size() != P || q_data[i] != 0) begin
        errors++; $display("FAIL relu_neg%0d: got %0d results data=%0d, want 8 results data=0", i, q_data.size(), q_data[i]);
      end
    end
    fill_uniform({4{4'h8}}, {4{4'h8}}, 0, 0);
    run_layer(-1, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < P; i++) begin
      checks++;
      if (q_data.size() != P || q_data[i] != 256) begin
        errors++; $display("FAIL relu_max%0d: got %0d results data=%0d, want 8 results data=256", i, q_data.size(), q_data[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_uniform({4{4'h1}}, {4{4'h2}}, 0, 10);
    run_layer(3, 7, 0, 0, 0, 0, 1'b0);
    checks++;
    if (hold_changed != 0 || prm_during_hold != 0) begin
      errors++; $display("FAIL bp_hold: changes=%0d prm_rd=%0d, want 0 and 0", hold_changed, prm_during_hold);
    end
    checks++;
    if (hs_cyc != 27 || resume_cyc != hs_cyc + 1 || resume_addr != 4) begin
      errors++; $display("FAIL bp_resume: handshake=%0d fetch=%0d addr=%0d, want 27 28 4", hs_cyc, resume_cyc, resume_addr);
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      checks++;
      if (q_idx[i] != i || q_data[i] != 8 + 10 * i) begin
        errors++; $display("FAIL bp_result%0d: got idx=%0d data=%0d, want idx=%0d data=%0d", i, q_idx[i], q_data[i], i, 8 + 10 * i);
      end
    end
    checks++;
    if (q_idx.size() != 8 || done_cnt != 1 || done_cyc != 48) begin
      errors++; $display("FAIL bp_done: results=%0d done=%0d cycle=%0d, want 8 1 48", q_idx.size(), done_cnt, done_cyc);
    end
  endtask

  task automatic test_start_busy();
    fill_uniform({4{4'h1}}, {4{4'h2}}, 3, 0);
    run_layer(-1, 0, 2, 20, 41, 0, 1'b0);
    checks++;
    if (q_idx.size() != 8 || done_cnt != 1 || done_cyc != 41) begin
      errors++; $display("FAIL busy_start: results=%0d done=%0d cycle=%0d, want 8 1 41", q_idx.size(), done_cnt, done_cyc);
    end
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_done_start: busy=%b after DONE, want 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || prm_rd !== 1'b0) begin
      errors++; $display("FAIL busy_idle: busy=%b prm_rd=%b, want 0 0", busy, prm_rd);
    end
  endtask

  task automatic test_mid_reset();
    fill_uniform({4{4'h1}}, {4{4'h2}}, 0, 10);
    run_layer(-1, 0, 0, 0, 0, 14, 1'b0);
    @(negedge clk);
    checks++;
    if ({busy, done, prm_rd, prm_addr, load_params, activation, weigth, bias, res_valid, res_data, res_idx} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b done=%b rd=%b load=%b act=%h w=%h b=%h valid=%b data=%h idx=%0d, want all 0",
               busy, done, prm_rd, load_params, activation, weigth, bias, res_valid, res_data, res_idx);
    end
    checks++;
    if (done_cnt != 0 || q_idx.size() != 2) begin
      errors++; $display("FAIL midrst_progress: done=%0d results=%0d, want 0 2", done_cnt, q_idx.size());
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: done=%b busy=%b want 0 0", done, busy); end
    run_layer(-1, 0, 0, 0, 0, 0, 1'b0);
    checks++;
    if (q_idx.size() != 8 || q_idx[0] != 0 || q_data[0] != 8 || done_cnt != 1) begin
      errors++; $display("FAIL midrst_restart: results=%0d first idx=%0d data=%0d done=%0d, want 8 0 8 1",
                         q_idx.size(), q_idx[0], q_data[0], done_cnt);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int l = 0; l < 200; l++) begin
      act_in = AW'($urandom);
      for (int i = 0; i < P; i++) begin
        rom_w[i] = WW'($urandom);
        rom_b[i] = (B+1)'($urandom);
      end
      run_layer(-1, 0, 0, 0, 0, 0, 1'b1);
      checks++;
      if (q_idx.size() != P || done_cnt != 1) begin
        errors++; $display("FAIL rand_count%0d: results=%0d done=%0d, want 8 1", l, q_idx.size(), done_cnt);
      end
      for (int i = 0; i < q_idx.size(); i++) begin
        checks++;
        if (q_idx[i] != i || q_data[i] != int'(golden(act_in, rom_w[i], rom_b[i]))) begin
          errors++;
          if (bad < 10) $display("FAIL rand_result l%0d n%0d: got idx=%0d data=%0d, want idx=%0d data=%0d",
                                 l, i, q_idx[i], q_data[i], i, int'(golden(act_in, rom_w[i], rom_b[i])));
          bad++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_start_busy();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_layer_seq.md
Name: neuron_layer_seq

Overview:
- Sequencer that reuses one combinational `neuron` instance (ReLU(bias + Σ a_i·w_i)) to evaluate a full layer of P neurons over a shared activation vector.
- Fetches each neuron's weight and bias set from an external parameter memory and drives the neuron's load_params pulse.
- Captures each result and hands it downstream through a valid/ready port.
- Sits between the layer's parameter store and the next layer's input buffer.

Parameters:
- M, 4, number of inputs per neuron (activation/weight pairs)
- N, 4, weight width (signed)
- K, 4, activation width (signed)
- B, 10, bias MSB index; the bias is B+1 bits, signed
- P, 8, neurons per layer; P ≥ 2
- Derived localparams, not overridable:
  - OW = N+K+$clog2(M)+2, neuron output width
  - IW = $clog2(P)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer; sampled only in IDLE
- act_in  in  M*K  activation vector; latched when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result handshakes
- prm_rd  out  1  parameter read strobe
- prm_addr  out  IW  neuron index being fetched
- prm_weigth  in  M*N  weight set; valid the cycle after prm_rd
- prm_bias  in  B+1  bias; valid the cycle after prm_rd
- load_params  out  1  load pulse to the neuron
- activation  out  M*K  to the neuron (latched act_in)
- weigth  out  M*N  to the neuron (registered)
- bias  out  B+1  to the neuron (registered)
- neu_out  in  OW  neuron output
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts
- res_data  out  OW  captured neuron output
- res_idx  out  IW  neuron index of res_data

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; idx, act, weigth, bias, res_data and res_idx registers are 0.
- Reset mid-layer: same as above on the next edge. No done pulse. The layer is abandoned.
- FSM states: IDLE, FETCH, WAIT, LOAD, CAPT, OUT, DONE.
  - IDLE: when start=1, latch act_in, set idx=0, go to FETCH. start is ignored in every other state.
  - FETCH: prm_rd=1, prm_addr=idx. Go to WAIT.
  - WAIT: register prm_weigth and prm_bias into the weigth and bias outputs. Go to LOAD.
  - LOAD: load_params=1 for exactly one cycle. Go to CAPT.
  - CAPT: res_data<=neu_out, res_idx<=idx. Go to OUT.
  - OUT: res_valid=1.
    - res_data and res_idx are held stable until res_valid&res_ready.
    - On handshake with idx==P-1, go to DONE.
    - On handshake otherwise, idx<=idx+1 and go to FETCH.
    - Without handshake, stay in OUT.
  - DONE: done=1 for one cycle. Go to IDLE.
- Timing: start seen at edge 0 gives FETCH in cycle 1, load_params in cycle 3, and res_valid from cycle 5.
- Throughput: with res_ready tied high, 5 cycles per neuron; a P=8 layer completes in 40 cycles plus the DONE cycle.
- Output signals:
  - load_params is decoded from the state; it is never high outside LOAD.
  - res_valid is decoded from the state.
  - The activation, weigth and bias outputs stay constant from LOAD through CAPT.
- Arithmetic: the block does none. neu_out is passed unmodified; the neuron performs the ReLU.
- No wrap: idx never exceeds P-1, and no prm_rd is issued after index P-1.
- A start pulse that coincides with the DONE cycle is ignored. A new layer needs start while in IDLE.

Decomposition:
- Package nn_pkg:
  - state enum encoding (3 bits)
  - OW and IW width functions, shared with the neuron bench
- Sub-module neuron_param_fetch is natural: the FETCH/WAIT prm_rd pulse plus the capture registers.
- The top-level FSM, index counter and result port stay in neuron_layer_seq.
- Integration bench instantiates neuron_layer_seq plus the existing `neuron` with the same M, N, K, B, and a 1-cycle-latency parameter ROM model.

Test Plan:
- Basic layer: act all 4'd1, weights all 4'd2, bias 11'sd3 for all 8 neurons, res_ready=1 → res_data=11 for idx 0..7; res_valid in cycles 5, 10, …, 40; done pulses in cycle 41.
- ReLU path: act 4'd1, weights 4'sd1, bias −20 → res_data=0. Same act with weights 4'sd−8, act 4'sd−8, bias 0 → res_data=256.
- Backpressure: res_ready low for 7 cycles on idx 3 → res_data/res_idx held; no prm_rd issued; resumes with idx 4 one cycle after the handshake.
- Start while busy: start pulsed in cycles 2 and 20 → ignored; exactly 8 results, one done pulse.
- Reset mid-layer: rst in cycle 14 → all outputs 0 next cycle, no done; a new start yields results from idx 0.
- Random: 200 layers, random act/weights/bias and random res_ready → every result equals the golden ReLU(bias+Σa·w), in index order.
